// File: rtl/nios2_debug_pkg.sv
// Shared types and constants for the Nios II debug slave command path.
// Contents: default widths, OCI channel indices, and the command entry struct
// at default widths.
package nios2_debug_pkg;

   localparam int unsigned DEF_SR_W        = 38;
   localparam int unsigned DEF_IR_W        = 2;
   localparam int unsigned DEF_NUM_CH      = 4;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_DEPTH       = 2;

   // Channel index equals the captured virtual IR value
   localparam int unsigned CH_OCIMEM = 0;
   localparam int unsigned CH_BREAK  = 1;
   localparam int unsigned CH_TRACE  = 2;
   localparam int unsigned CH_SPARE  = 3;

   typedef struct packed {
      logic [DEF_IR_W-1:0] ir;
      logic [DEF_SR_W-1:0] data;
   } cmd_t;

endpackage

// File: rtl/nios2_debug_slave_cmd_sync_toggle_sync.sv
// debug_toggle_sync: brings a TCK-domain toggle into clk and emits a one-cycle
// pulse each time the synchronised level changes.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   tgl           TCK-domain toggle (asynchronous to clk)
//   pulse         high for one clk while synchronised level differs from its
//                 delayed copy
module debug_toggle_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tgl,
   output logic pulse
);

   logic [STAGES-1:0] chain;
   logic              delayed;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain   <= '0;
         delayed <= 1'b0;
      end else begin
         chain   <= {chain[STAGES-2:0], tgl};
         delayed <= chain[STAGES-1];
      end
   end

   assign pulse = chain[STAGES-1] ^ delayed;

endmodule

// File: rtl/nios2_debug_slave_cmd_sync.sv
// nios2_debug_slave_cmd_sync: system-clock half of the debug slave.
// Synchronises update-DR / update-IR toggles, captures {ir_in, sr} into a
// show-ahead command FIFO and offers the head to the channel selected by its IR.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   udr_tgl        TCK toggle per update-DR (pushes a command)
//   uir_tgl        TCK toggle per update-IR (drives ir_update)
//   ir_in, sr      command snapshot, stable around each toggle
//   cmd_valid      one-hot head target, cmd_ready per-channel accept
//   jdo            head data
//   ir_update      one-clk pulse per update-IR
//   overrun        sticky: push dropped, FIFO full
//   bad_ir         sticky: push dropped, IR out of channel range
//   err_clr        clears sticky flags (a same-cycle set wins)
//   fifo_level     entries held
module nios2_debug_slave_cmd_sync
   import nios2_debug_pkg::*;
#(
   parameter int unsigned SR_W        = DEF_SR_W,
   parameter int unsigned IR_W        = DEF_IR_W,
   parameter int unsigned NUM_CH      = DEF_NUM_CH,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned DEPTH       = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       udr_tgl,
   input  logic                       uir_tgl,
   input  logic [IR_W-1:0]            ir_in,
   input  logic [SR_W-1:0]            sr,
   output logic [NUM_CH-1:0]          cmd_valid,
   input  logic [NUM_CH-1:0]          cmd_ready,
   output logic [SR_W-1:0]            jdo,
   output logic                       ir_update,
   output logic                       overrun,
   output logic                       bad_ir,
   input  logic                       err_clr,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = PW + 1;
   localparam int unsigned LVL_W = $clog2(DEPTH+1);
   localparam int unsigned ARM_N = SYNC_STAGES + 1;
   localparam int unsigned ARM_W = $clog2(ARM_N + 1);

   if ((1 << IR_W) < NUM_CH) begin : g_chk_ir
      $error("IR_W too narrow to address NUM_CH channels");
   end
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (DEPTH < 2 || (1 << PW) != DEPTH) begin : g_chk_depth
      $error("DEPTH must be a power of 2 and at least 2");
   end

   typedef struct packed {
      logic [IR_W-1:0] ir;
      logic [SR_W-1:0] data;
   } entry_t;

   logic             udr_ev;
   logic             uir_ev;
   logic [ARM_W-1:0] arm_cnt;
   logic             armed;
   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] level;
   logic             empty;
   logic             full;
   logic             udr_fire;
   logic             ir_oob;
   logic             pop;
   logic             push;
   logic             set_ovr;
   logic             set_bad;

   debug_toggle_sync #(.STAGES(SYNC_STAGES)) u_udr_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .tgl     (udr_tgl),
      .pulse   (udr_ev)
   );

   debug_toggle_sync #(.STAGES(SYNC_STAGES)) u_uir_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .tgl     (uir_tgl),
      .pulse   (uir_ev)
   );

   // Events are ignored until the sync chains have flushed whatever level the
   // TCK side left on the toggles during reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arm_cnt <= '0;
      end else if (!armed) begin
         arm_cnt <= arm_cnt + ARM_W'(1);
      end
   end

   assign armed = (arm_cnt == ARM_W'(ARM_N));

   assign level = wr_ptr - rd_ptr;
   assign empty = (level == '0);
   assign full  = (level == PTR_W'(DEPTH));
   assign head  = mem[rd_ptr[PW-1:0]];

   always_comb begin
      cmd_valid = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cmd_valid[i] = !empty && (head.ir == IR_W'(i));
      end
   end

   assign jdo        = empty ? '0 : head.data;
   assign fifo_level = LVL_W'(level);

   assign udr_fire = udr_ev && armed;
   assign ir_oob   = (32'(ir_in) >= NUM_CH);
   assign pop      = |(cmd_valid & cmd_ready);
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push     = udr_fire && !ir_oob && (!full || pop);
   assign set_ovr  = udr_fire && !ir_oob && full && !pop;
   assign set_bad  = udr_fire && ir_oob;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[PW-1:0]] <= entry_t'{ir: ir_in, data: sr};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ir_update <= 1'b0;
         overrun   <= 1'b0;
         bad_ir    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         ir_update <= uir_ev && armed;
         if (set_ovr) begin
            overrun <= 1'b1;
         end else if (err_clr) begin
            overrun <= 1'b0;
         end
         if (set_bad) begin
            bad_ir <= 1'b1;
         end else if (err_clr) begin
            bad_ir <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nios2_debug_slave_cmd_sync.sv
// Directed bench for nios2_debug_slave_cmd_sync: default 4-channel build plus a
// 3-channel build for the out-of-range IR case. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_nios2_debug_slave_cmd_sync;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        udr_tgl;
   logic        uir_tgl;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic [3:0]  cmd_valid;
   logic [3:0]  cmd_ready;
   logic [37:0] jdo;
   logic        ir_update;
   logic        overrun;
   logic        bad_ir;
   logic        err_clr;
   logic [1:0]  fifo_level;

   logic        udr3;
   logic        uir3;
   logic [1:0]  ir3;
   logic [2:0]  cmd_valid3;
   logic [2:0]  cmd_ready3;
   logic [37:0] jdo3;
   logic        ir_update3;
   logic        overrun3;
   logic        bad_ir3;
   logic        err_clr3;
   logic [1:0]  fifo_level3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nios2_debug_slave_cmd_sync dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .udr_tgl    (udr_tgl),
      .uir_tgl    (uir_tgl),
      .ir_in      (ir_in),
      .sr         (sr),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .jdo        (jdo),
      .ir_update  (ir_update),
      .overrun    (overrun),
      .bad_ir     (bad_ir),
      .err_clr    (err_clr),
      .fifo_level (fifo_level)
   );

   nios2_debug_slave_cmd_sync #(.NUM_CH(3)) dut3 (
      .clk        (clk),
      .reset_n    (reset_n),
      .udr_tgl    (udr3),
      .uir_tgl    (uir3),
      .ir_in      (ir3),
      .sr         (sr),
      .cmd_valid  (cmd_valid3),
      .cmd_ready  (cmd_ready3),
      .jdo        (jdo3),
      .ir_update  (ir_update3),
      .overrun    (overrun3),
      .bad_ir     (bad_ir3),
      .err_clr    (err_clr3),
      .fifo_level (fifo_level3)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one update-DR command and wait 4 clk (spacing > SYNC_STAGES+1).
   task automatic send_cmd(input logic [1:0] ir, input logic [37:0] data);
      ir_in   = ir;
      sr      = data;
      udr_tgl = ~udr_tgl;
      tick(4);
   endtask

   initial begin
      reset_n    = 1'b0;
      udr_tgl    = 1'b1;
      uir_tgl    = 1'b0;
      ir_in      = '0;
      sr         = '0;
      cmd_ready  = '0;
      err_clr    = 1'b0;
      udr3       = 1'b0;
      uir3       = 1'b0;
      ir3        = '0;
      cmd_ready3 = '0;
      err_clr3   = 1'b0;

      // 1: reset values, toggle held at 1 across release is not an event
      tick(3);
      check("rst_valid", 64'(cmd_valid), 64'h0);
      check("rst_jdo", 64'(jdo), 64'h0);
      check("rst_level", 64'(fifo_level), 64'h0);
      check("rst_overrun", 64'(overrun), 64'h0);
      check("rst_bad_ir", 64'(bad_ir), 64'h0);
      check("rst_ir_update", 64'(ir_update), 64'h0);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("arm_valid", 64'(cmd_valid), 64'h0);
         check("arm_ir_update", 64'(ir_update), 64'h0);
      end
      check("arm_level", 64'(fifo_level), 64'h0);

      // 2: single command, latency SYNC_STAGES+1, held until accepted
      ir_in   = 2'd1;
      sr      = 38'h2A_DEAD_BEEF;
      udr_tgl = ~udr_tgl;
      tick(1);
      check("lat1_valid", 64'(cmd_valid), 64'h0);
      tick(1);
      check("lat2_valid", 64'(cmd_valid), 64'h0);
      tick(1);
      check("lat3_valid", 64'(cmd_valid), 64'h2);
      check("lat3_jdo", 64'(jdo), 64'h2A_DEAD_BEEF);
      check("lat3_level", 64'(fifo_level), 64'h1);
      cmd_ready = 4'b1101;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("hold_valid", 64'(cmd_valid), 64'h2);
         check("hold_jdo", 64'(jdo), 64'h2A_DEAD_BEEF);
      end
      cmd_ready = 4'b0010;
      tick(1);
      cmd_ready = '0;
      check("pop_valid", 64'(cmd_valid), 64'h0);
      check("pop_level", 64'(fifo_level), 64'h0);

      // 3: three commands into a 2-deep FIFO, third overruns
      send_cmd(2'd0, 38'h11_2233_4455);
      send_cmd(2'd2, 38'h05_0505_0505);
      send_cmd(2'd3, 38'h3F_0000_0001);
      check("ovr_flag", 64'(overrun), 64'h1);
      check("ovr_level", 64'(fifo_level), 64'h2);
      check("ovr_head_valid", 64'(cmd_valid), 64'h1);
      check("ovr_head_jdo", 64'(jdo), 64'h11_2233_4455);
      cmd_ready = 4'b1111;
      tick(1);
      check("drain1_valid", 64'(cmd_valid), 64'h4);
      check("drain1_jdo", 64'(jdo), 64'h05_0505_0505);
      check("drain1_level", 64'(fifo_level), 64'h1);
      tick(1);
      cmd_ready = '0;
      check("drain2_valid", 64'(cmd_valid), 64'h0);
      check("drain2_level", 64'(fifo_level), 64'h0);
      check("ovr_sticky", 64'(overrun), 64'h1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("ovr_clr", 64'(overrun), 64'h0);

      // 4: push into a full FIFO on the same edge as a pop
      send_cmd(2'd1, 38'h01_0000_00C0);
      send_cmd(2'd2, 38'h02_0000_00D0);
      check("full_level", 64'(fifo_level), 64'h2);
      ir_in   = 2'd3;
      sr      = 38'h03_0000_00E0;
      udr_tgl = ~udr_tgl;
      tick(2);
      check("full_pre_level", 64'(fifo_level), 64'h2);
      cmd_ready = 4'b0010;
      tick(1);
      cmd_ready = '0;
      check("simul_overrun", 64'(overrun), 64'h0);
      check("simul_level", 64'(fifo_level), 64'h2);
      check("simul_valid", 64'(cmd_valid), 64'h4);
      check("simul_jdo", 64'(jdo), 64'h02_0000_00D0);
      cmd_ready = 4'b1111;
      tick(1);
      check("last_valid", 64'(cmd_valid), 64'h8);
      check("last_jdo", 64'(jdo), 64'h03_0000_00E0);
      tick(1);
      cmd_ready = '0;
      check("last_level", 64'(fifo_level), 64'h0);

      // 5: 3-channel build, IR out of range
      ir3  = 2'd3;
      udr3 = ~udr3;
      tick(3);
      check("bad_set", 64'(bad_ir3), 64'h1);
      check("bad_level", 64'(fifo_level3), 64'h0);
      check("bad_valid", 64'(cmd_valid3), 64'h0);
      err_clr3 = 1'b1;
      tick(1);
      err_clr3 = 1'b0;
      check("bad_clr", 64'(bad_ir3), 64'h0);
      udr3 = ~udr3;
      tick(2);
      err_clr3 = 1'b1;
      tick(1);
      err_clr3 = 1'b0;
      check("bad_set_wins", 64'(bad_ir3), 64'h1);
      tick(1);
      ir3  = 2'd2;
      udr3 = ~udr3;
      tick(3);
      check("ch3_valid", 64'(cmd_valid3), 64'h4);
      check("ch3_level", 64'(fifo_level3), 64'h1);
      cmd_ready3 = 3'b100;
      tick(1);
      cmd_ready3 = '0;
      check("ch3_pop", 64'(fifo_level3), 64'h0);

      // ir_update pulse, independent of the queue
      send_cmd(2'd0, 38'h00_1234_5678);
      uir_tgl = ~uir_tgl;
      tick(2);
      check("uir_early", 64'(ir_update), 64'h0);
      tick(1);
      check("uir_pulse", 64'(ir_update), 64'h1);
      check("uir_keep_level", 64'(fifo_level), 64'h1);
      tick(1);
      check("uir_end", 64'(ir_update), 64'h0);

      // 6: async reset with two entries queued and a handshake pending
      send_cmd(2'd3, 38'h3A_BCDE_F012);
      check("pre_rst_level", 64'(fifo_level), 64'h2);
      cmd_ready = 4'b0001;
      #2;
      reset_n = 1'b0;
      #1;
      check("async_valid", 64'(cmd_valid), 64'h0);
      check("async_level", 64'(fifo_level), 64'h0);
      check("async_jdo", 64'(jdo), 64'h0);
      cmd_ready = '0;
      tick(2);
      reset_n = 1'b1;
      tick(5);
      check("post_rst_valid", 64'(cmd_valid), 64'h0);
      check("post_rst_level", 64'(fifo_level), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
